// File: rtl/gps_spi_rx.sv
// Receive-side deserializer for the GPS sample SPI link. It synchronizes SCK/SS/MOSI,
// packs {I0,I1,Q0,Q1} nibbles into words and queues them in a first-word-fall-through FIFO.
module gps_spi_rx #(
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int SYNC_STAGES      = 2,
  localparam int W   = 4 * SAMPLES_PER_WORD,
  localparam int AW  = $clog2(FIFO_DEPTH),
  localparam int SCW = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1
) (
  input  logic          CLK_100_000,
  input  logic          RESET_N,
  input  logic          SPI_SCK,
  input  logic          SPI_SS,
  input  logic          SPI_MOSI,
  output logic [W-1:0]  WORD_DATA,
  output logic          WORD_VALID,
  input  logic          WORD_READY,
  output logic [AW:0]   FIFO_LEVEL,
  output logic          OVERFLOW,
  output logic          FRAME_ERR,
  input  logic          CLEAR_ERR
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_dly_q, ss_dly_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   armed_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise_s, ss_rise_s, ss_fall_s;

  logic [0:0]     state_q, state_d;
  logic [1:0]     bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0] smp_cnt_q, smp_cnt_d;
  logic [3:0]     nibble_q, nibble_d, nib_shift_s;
  logic [W-1:0]   word_q, word_d;
  logic           push_s, frame_set_s;

  logic [W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    level_q, level_d;
  logic           overflow_q, frame_err_q;
  logic           full_s, pop_s, push_ok_s, ovf_set_s;

  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign ss_s       = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_dly_q;
  assign ss_rise_s  = ss_s & ~ss_dly_q;
  // A fall only counts once SS has genuinely been seen high after reset, so a
  // transfer already running at reset release is ignored until SS cycles.
  assign ss_fall_s  = armed_q & ss_dly_q & ~ss_s;

  // Input synchronizers, edge-detect delay flops and post-reset arming
  always_ff @(posedge CLK_100_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      ss_dly_q    <= 1'b1;
      warm_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      sck_dly_q   <= sck_s;
      ss_dly_q    <= ss_s;
      warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_q | (warm_q[SYNC_STAGES] & ss_s);
    end
  end

  // Frame FSM: bit/nibble/word assembly and frame error detection
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    nibble_d    = nibble_q;
    word_d      = word_q;
    nib_shift_s = {nibble_q[2:0], mosi_s};
    push_s      = 1'b0;
    frame_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ss_fall_s) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 2'd0;
          nibble_d  = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (sck_rise_s) begin
          nibble_d  = nib_shift_s;
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) begin
            word_d = {word_q[W-5:0], nib_shift_s};
            if (smp_cnt_q == SCW'(SAMPLES_PER_WORD - 1)) begin
              push_s    = 1'b1;
              smp_cnt_d = '0;
            end else begin
              smp_cnt_d = smp_cnt_q + SCW'(1);
            end
          end else begin
            word_d = word_q;
          end
        end else begin
          nibble_d = nibble_q;
        end
        // The bit on a coincident SCK edge is taken first, so judge the updated count
        if (ss_rise_s) begin
          state_d = ST_IDLE;
          if (bit_cnt_d != 2'd0) begin
            frame_set_s = 1'b1;
            bit_cnt_d   = 2'd0;
            nibble_d    = 4'd0;
          end else begin
            frame_set_s = 1'b0;
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame FSM state registers
  always_ff @(posedge CLK_100_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 2'd0;
      smp_cnt_q <= '0;
      nibble_q  <= 4'd0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      nibble_q  <= nibble_d;
      word_q    <= word_d;
    end
  end

  assign full_s    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign pop_s     = (level_q != '0) & WORD_READY;
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // FIFO occupancy next-state
  always_comb begin
    level_d = level_q;
    case ({push_ok_s, pop_s})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO storage, pointers, level and sticky error flags
  always_ff @(posedge CLK_100_000 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= word_d;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q     <= level_d;
      overflow_q  <= ovf_set_s | (overflow_q & ~CLEAR_ERR);
      frame_err_q <= frame_set_s | (frame_err_q & ~CLEAR_ERR);
    end
  end

  assign WORD_DATA  = mem_q[rd_ptr_q];
  assign WORD_VALID = (level_q != '0);
  assign FIFO_LEVEL = level_q;
  assign OVERFLOW   = overflow_q;
  assign FRAME_ERR  = frame_err_q;

endmodule

// File: tb/tb_gps_spi_rx.sv
// Directed self-checking bench for gps_spi_rx: bursts, split frames, frame errors,
// FIFO overflow, simultaneous push/pop and mid-transfer reset.
module tb_gps_spi_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        ss = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        frame_err;
  logic        clear_err = 1'b0;

  int total = 0;
  int bad = 0;

  gps_spi_rx dut (
    .CLK_100_000 (clk),
    .RESET_N     (rst_n),
    .SPI_SCK     (sck),
    .SPI_SS      (ss),
    .SPI_MOSI    (mosi),
    .WORD_DATA   (word_data),
    .WORD_VALID  (word_valid),
    .WORD_READY  (word_ready),
    .FIFO_LEVEL  (fifo_level),
    .OVERFLOW    (overflow),
    .FRAME_ERR   (frame_err),
    .CLEAR_ERR   (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) mosi = b;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (3) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    for (int i = 3; i >= 0; i--) send_bit(n[i]);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  // mode 1: check push latency on the final bit; mode 2: pop exactly at the push edge
  task automatic send_word_tail(input logic [15:0] w, input int mode);
    for (int i = 15; i >= 1; i--) send_bit(w[i]);
    @(negedge clk) mosi = w[0];
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    if (mode == 1) chk("lat_not_yet", {31'd0, word_valid}, 32'd0);
    if (mode == 2) word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    if (mode == 1) chk("lat_valid", {31'd0, word_valid}, 32'd1);
    repeat (1) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge clk) ss = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ss_high();
    @(negedge clk) ss = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk) word_ready = 1'b1;
    @(negedge clk) word_ready = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, word_valid}, 32'd0);
    chk({tag, "_data"},  {16'd0, word_data}, 32'd0);
    chk({tag, "_level"}, {28'd0, fifo_level}, 32'd0);
    chk({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    chk({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    logic [15:0] w;
    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk_zero("reset");

    // One burst A,5,F,0 with push-latency check
    ss_low();
    send_word_tail(16'hA5F0, 1);
    ss_high();
    chk("b1_valid", {31'd0, word_valid}, 32'd1);
    chk("b1_data",  {16'd0, word_data}, 32'h0000A5F0);
    chk("b1_level", {28'd0, fifo_level}, 32'd1);
    chk("b1_ovf",   {31'd0, overflow}, 32'd0);
    chk("b1_ferr",  {31'd0, frame_err}, 32'd0);
    pop();
    chk("b1_popped_valid", {31'd0, word_valid}, 32'd0);
    chk("b1_popped_level", {28'd0, fifo_level}, 32'd0);

    // Same word across four SS bursts
    w = 16'hA5F0;
    for (int k = 3; k >= 0; k--) begin
      ss_low();
      send_nib(w[k*4 +: 4]);
      ss_high();
      if (k > 0) chk("split_partial_level", {28'd0, fifo_level}, 32'd0);
    end
    chk("split_data",  {16'd0, word_data}, 32'h0000A5F0);
    chk("split_level", {28'd0, fifo_level}, 32'd1);
    chk("split_ferr",  {31'd0, frame_err}, 32'd0);
    pop();

    // Frame error: 6 bits then SS high; 2-bit remainder dropped
    ss_low();
    send_nib(4'hA);
    send_bit(1'b1);
    send_bit(1'b0);
    ss_high();
    chk("ferr_set",   {31'd0, frame_err}, 32'd1);
    chk("ferr_level", {28'd0, fifo_level}, 32'd0);
    ss_low();
    send_nib(4'h1);
    send_nib(4'h2);
    send_nib(4'h3);
    ss_high();
    chk("ferr_word",  {16'd0, word_data}, 32'h0000A123);
    chk("ferr_level1", {28'd0, fifo_level}, 32'd1);
    chk("ferr_still", {31'd0, frame_err}, 32'd1);
    clr();
    chk("ferr_clear", {31'd0, frame_err}, 32'd0);
    pop();

    // Overflow: 9 words with no consumer
    ss_low();
    for (int i = 1; i <= 9; i++) send_word(16'(i) * 16'h1111);
    ss_high();
    chk("ovf_level", {28'd0, fifo_level}, 32'd8);
    chk("ovf_flag",  {31'd0, overflow}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", {16'd0, word_data}, {16'd0, 16'(i) * 16'h1111});
      pop();
    end
    chk("ovf_empty", {31'd0, word_valid}, 32'd0);
    clr();
    chk("ovf_clear", {31'd0, overflow}, 32'd0);

    // Full FIFO with pop coinciding with the ninth push
    ss_low();
    for (int i = 1; i <= 8; i++) send_word(16'(i) * 16'h1111);
    chk("pp_full", {28'd0, fifo_level}, 32'd8);
    send_word_tail(16'h9999, 2);
    ss_high();
    chk("pp_level", {28'd0, fifo_level}, 32'd8);
    chk("pp_ovf",   {31'd0, overflow}, 32'd0);
    for (int i = 2; i <= 9; i++) begin
      chk("pp_order", {16'd0, word_data}, {16'd0, 16'(i) * 16'h1111});
      pop();
    end
    chk("pp_empty", {31'd0, word_valid}, 32'd0);

    // Reset mid-transfer, released with SS still low
    ss_low();
    w = 16'hA5F0;
    for (int i = 15; i >= 9; i--) send_bit(w[i]);
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 8; i >= 0; i--) send_bit(w[i]);
    repeat (6) @(negedge clk);
    chk_zero("rst_mid");
    ss_high();
    chk("rst_ss_ferr", {31'd0, frame_err}, 32'd0);
    ss_low();
    send_word(16'h3C5A);
    ss_high();
    chk("rst_fresh_data",  {16'd0, word_data}, 32'h00003C5A);
    chk("rst_fresh_level", {28'd0, fifo_level}, 32'd1);
    chk("rst_fresh_ferr",  {31'd0, frame_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gps_spi_rx.md
# gps_spi_rx

Receive-side deserializer for the GPS sample SPI link: it captures the 4-bit {I0,I1,Q0,Q1} sample groups that the CPLD bridge shifts out on SCK/SS/MOSI and packs consecutive samples into words. It queues completed words in a small first-word-fall-through FIFO with a valid/ready output. It sits at the far end of the link on an FPGA/MCU-side fabric clocked at 100 MHz, oversampling the 25 MHz SCK through synchronizers.

## Interface
- SAMPLES_PER_WORD, 4: samples packed per output word; word width W = 4*SAMPLES_PER_WORD.
- FIFO_DEPTH, 8: word FIFO depth; power of two, ≥2.
- SYNC_STAGES, 2: synchronizer flops on SPI_SCK, SPI_SS and SPI_MOSI; ≥2.

- CLK_100_000  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- SPI_SCK  in  1  link clock from the bridge; data is valid on its rising edge.
- SPI_SS  in  1  link select, active low.
- SPI_MOSI  in  1  link data, sent in the order I0, I1, Q0, Q1.
- WORD_DATA  out  W  FIFO head word. The first sample of the word is in bits [W-1:W-4]. Within each nibble, I0 is the MSB and Q1 the LSB.
- WORD_VALID  out  1  FIFO not empty.
- WORD_READY  in  1  consumer pop; a pop occurs when WORD_VALID & WORD_READY.
- FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  words currently stored.
- OVERFLOW  out  1  sticky: a completed word was dropped because the FIFO was full.
- FRAME_ERR  out  1  sticky: SS deasserted with a partial nibble.
- CLEAR_ERR  in  1  synchronous clear of OVERFLOW and FRAME_ERR.

## Operation
- Synchronizers:
  - Reset state is SCK=0, SS=1, MOSI=0.
  - sck_rise = sck_s & ~sck_d (one extra delay flop). ss_rise and ss_fall are detected the same way.
  - MOSI uses the same stage count as SCK, so the bit sampled on sck_rise is the synchronized MOSI from the same cycle.
- FSM with two states:
  - IDLE: the reset state. SS is high and all SCK edges are ignored. ss_fall moves to ACTIVE and sets bit_cnt=0.
  - ACTIVE: on each sck_rise, shift MOSI into a 4-bit nibble register and increment bit_cnt (mod 4).
  - When bit_cnt==3 on an sck_rise, the nibble completes: append it to the word assembly register and increment smp_cnt.
  - If smp_cnt==SAMPLES_PER_WORD-1 at that point, the word completes: push it to the FIFO and set smp_cnt=0.
  - ss_rise returns to IDLE. If bit_cnt≠0, the partial nibble is discarded, bit_cnt is set to 0 and FRAME_ERR is set.
- Partial words (smp_cnt>0) are kept across SS deassertion, because the bridge releases SS between bursts while the sample stream continues.
- Simultaneous events:
  - sck_rise and ss_rise in the same cycle: the bit is accepted first, then the ss_rise check uses the updated bit_cnt. Completing bit 3 this way is not an error.
  - Push and pop in the same cycle: FIFO_LEVEL is unchanged. This is allowed even when full; the push is accepted.
  - Push when full with no pop: the word is dropped, OVERFLOW is set, and FIFO contents are unchanged.
  - WORD_READY while empty: ignored.
  - CLEAR_ERR in the same cycle as a new error: the error wins and the flag remains 1.
- FIFO pointers wrap modulo FIFO_DEPTH, and FIFO_LEVEL saturates at FIFO_DEPTH.
- RESET_N low, including mid-transfer, asynchronously sets:
  - FSM=IDLE, bit_cnt=0, smp_cnt=0, nibble=0, word=0.
  - FIFO emptied.
  - WORD_DATA=0, WORD_VALID=0, FIFO_LEVEL=0, OVERFLOW=0, FRAME_ERR=0.
  - Synchronizers to their idle values.
- After reset release, the block waits in IDLE for the next ss_fall. A transfer already in progress is therefore ignored until SS cycles high and then low.

## Timing
- Input requirements:
  - SPI_SCK high and low times ≥ 2 CLK_100_000 periods each. 25 MHz at 50% duty gives 2.
  - MOSI stable ≥ 1 CLK period before and after each SCK rising edge.
  - SS falling ≥ 2 CLK periods before the first SCK rise.
- Push latency: a word completed by SCK rise k is in the FIFO, with WORD_VALID=1, after SYNC_STAGES+1 CLK rising edges. The count includes the edge at which stage 1 first captures SCK high.
- FIFO is first-word fall-through: WORD_DATA is the head whenever WORD_VALID=1.
- A pop at edge n presents the next word (or WORD_VALID=0) after edge n.
- FIFO_LEVEL, OVERFLOW and FRAME_ERR are registered and update at the same edge as the causing push, pop or SS edge.
- WORD_DATA is don't-care when WORD_VALID=0, except that it is 0 after reset.

## Test plan
- Reset, then one burst with SS low and 16 SCK pulses carrying nibbles 0xA, 0x5, 0xF, 0x0, WORD_READY=0 → after the final edge plus SYNC_STAGES+1 cycles: WORD_VALID=1, WORD_DATA=16'hA5F0, FIFO_LEVEL=1, no flags.
- Same 16 bits split into four SS bursts of 4 SCK each, SS high for 10 cycles between bursts → WORD_DATA=16'hA5F0 with FRAME_ERR=0. This proves the partial word is retained across SS.
- SS low, 6 SCK pulses, then SS high → FRAME_ERR=1. The 2-bit remainder is discarded. The next burst of 12 SCK (0x1, 0x2, 0x3) produces word {0xA?-first nibble from first 4 bits, 0x1, 0x2, 0x3} → WORD_DATA=16'hA123 when the first 4 bits are 0xA. CLEAR_ERR then sets FRAME_ERR=0.
- WORD_READY=0, 9 words streamed → FIFO_LEVEL=8, OVERFLOW=1. Popping the FIFO returns words 1–8 in order; word 9 is lost.
- With FIFO full, WORD_READY=1 held while word 9 completes → push and pop in the same cycle: FIFO_LEVEL stays 8, OVERFLOW=0, and word 9 appears as the 8th word after word 1 is popped.
- RESET_N pulsed low after 7 SCK of a burst, then released while SS is still low, followed by 9 more SCK → no word is produced, WORD_VALID=0, and all outputs are 0. A fresh SS cycle with 16 SCK then produces a normal word.
